// File: rtl/multiword_add_sequencer.sv
// Serial multi-word adder: one WIDTH-bit slice per cycle, LSB first, with valid/ready start and result.
// Optional subtract mode is compiled in by defining MWADD_SUB_EN (adds the op_sub port).
module multiword_add_sequencer #(
    parameter int WIDTH = 8,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [WIDTH*WORDS-1:0] op_a,
    input  logic [WIDTH*WORDS-1:0] op_b,
    input  logic                   carry_in,
`ifdef MWADD_SUB_EN
    input  logic                   op_sub,
`endif
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [WIDTH*WORDS-1:0] result,
    output logic                   carry_out,
    output logic                   busy,
    output logic [1:0]             fsm_state
);

    localparam int N     = WIDTH * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     a_reg;
    logic [N-1:0]     b_reg;
    logic             carry_reg;
    logic [N-1:0]     b_load;
    logic             carry_load;
    logic             accept;
    logic             last_slice;
    logic [WIDTH:0]   slice_sum;

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // start_ready is high only in IDLE and res_valid only in DONE, so a result handshake
    // (DONE -> IDLE) can never coincide with an acceptance; the next start waits one edge.
    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign fsm_state   = state;

    assign accept     = start_valid && (state == IDLE);
    assign last_slice = (idx == LAST_IDX);

    // Subtraction is a + ~b + 1, so the forced carry replaces carry_in.
    always_comb begin
`ifdef MWADD_SUB_EN
        b_load     = op_sub ? ~op_b : op_b;
        carry_load = op_sub ? 1'b1 : carry_in;
`else
        b_load     = op_b;
        carry_load = carry_in;
`endif
    end

    // Operand registers shift right each RUN cycle, so the active slice is always the low one.
    assign slice_sum = {1'b0, a_reg[WIDTH-1:0]}
                     + {1'b0, b_reg[WIDTH-1:0]}
                     + {{WIDTH{1'b0}}, carry_reg};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_valid) state_nxt = RUN;
            RUN:     if (last_slice)  state_nxt = DONE;
            DONE:    if (res_ready)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            a_reg     <= op_a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
        end else if (state == RUN) begin
            a_reg     <= a_reg >> WIDTH;
            b_reg     <= b_reg >> WIDTH;
            carry_reg <= slice_sum[WIDTH];
            idx       <= last_slice ? '0 : idx + IDX_W'(1);
            for (int k = 0; k < WORDS; k++) begin
                if (idx == IDX_W'(k)) begin
                    result[k*WIDTH +: WIDTH] <= slice_sum[WIDTH-1:0];
                end
            end
            if (last_slice) begin
                carry_out <= slice_sum[WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (WIDTH=8, WORDS=4): vector table plus
// hand-written reset-abort and back-to-back sequences.
module tb_multiword_add_sequencer;

    localparam int WIDTH = 8;
    localparam int WORDS = 4;
    localparam int N     = WIDTH * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [N-1:0] op_a = '0;
    logic [N-1:0] op_b = '0;
    logic         carry_in = 1'b0;
`ifdef MWADD_SUB_EN
    logic         op_sub = 1'b0;
`endif
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [N-1:0] result;
    logic         carry_out;
    logic         busy;
    logic [1:0]   fsm_state;

    multiword_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .carry_in    (carry_in),
`ifdef MWADD_SUB_EN
        .op_sub      (op_sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .carry_out   (carry_out),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic         sub;
        int           hold;
        logic [N-1:0] res;
        logic         co;
    } vec_t;

    vec_t         vecs[$];
    logic [N-1:0] exp_q[$];
    logic         exp_co_q[$];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic cin, input logic sub);
        op_a        = a;
        op_b        = b;
        carry_in    = cin;
`ifdef MWADD_SUB_EN
        op_sub      = sub;
`else
        if (sub) $display("note: subtract vector skipped in add-only build");
`endif
        start_valid = 1'b1;
    endtask

    // Waits from just after an acceptance edge until res_valid; checks latency and busy.
    task automatic wait_result(input string name);
        int cycles;
        cycles = 0;
        while (!res_valid && cycles < 20) begin
            check({name, "_busy"}, 64'(busy), 64'd1);
            tick();
            cycles++;
        end
        check({name, "_latency"}, 64'(cycles), 64'(WORDS));
    endtask

    // Scoreboard: pops the expected result/carry and compares against DONE outputs.
    task automatic score(input string name);
        logic [N-1:0] er;
        logic         ec;
        er = exp_q.pop_front();
        ec = exp_co_q.pop_front();
        check({name, "_result"}, 64'(result), 64'(er));
        check({name, "_carry"}, 64'(carry_out), 64'(ec));
    endtask

    task automatic run_vec(input vec_t v, input string name);
        logic [N-1:0] er;
        logic         ec;
        exp_q.push_back(v.res);
        exp_co_q.push_back(v.co);
        drive_start(v.a, v.b, v.cin, v.sub);
        check({name, "_ready_idle"}, 64'(start_ready), 64'd1);
        tick();
        // Scramble operands after acceptance; in-flight op must ignore them.
        start_valid = 1'b0;
        op_a        = ~v.a;
        op_b        = ~v.b;
        carry_in    = ~v.cin;
        wait_result(name);
        er = exp_q[0];
        ec = exp_co_q[0];
        score(name);
        for (int h = 0; h < v.hold; h++) begin
            tick();
            check({name, "_hold_result"}, 64'(result), 64'(er));
            check({name, "_hold_carry"}, 64'(carry_out), 64'(ec));
            check({name, "_hold_ready"}, 64'(start_ready), 64'd0);
            check({name, "_hold_valid"}, 64'(res_valid), 64'd1);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, "_idle_valid"}, 64'(res_valid), 64'd0);
        check({name, "_idle_ready"}, 64'(start_ready), 64'd1);
        check({name, "_idle_keep"}, 64'(result), 64'(er));
    endtask

    initial begin
        vecs.push_back('{a: 32'hFFFF_FFFF, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, hold: 0, res: 32'h0000_0000, co: 1'b1});
        vecs.push_back('{a: 32'h1234_5678, b: 32'h1111_1111, cin: 1'b1, sub: 1'b0, hold: 3, res: 32'h2345_678A, co: 1'b0});
        vecs.push_back('{a: 32'h0000_0000, b: 32'h0000_0000, cin: 1'b1, sub: 1'b0, hold: 1, res: 32'h0000_0001, co: 1'b0});
        vecs.push_back('{a: 32'h8000_0000, b: 32'h8000_0000, cin: 1'b0, sub: 1'b0, hold: 0, res: 32'h0000_0000, co: 1'b1});
        vecs.push_back('{a: 32'h00FF_00FF, b: 32'h0001_0001, cin: 1'b0, sub: 1'b0, hold: 0, res: 32'h0100_0100, co: 1'b0});
        vecs.push_back('{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, cin: 1'b1, sub: 1'b0, hold: 2, res: 32'hFFFF_FFFF, co: 1'b1});
        vecs.push_back('{a: 32'hDEAD_BEEF, b: 32'h0123_4567, cin: 1'b0, sub: 1'b0, hold: 0, res: 32'hDFD1_0456, co: 1'b0});
        vecs.push_back('{a: 32'h0000_FFFF, b: 32'h0000_0001, cin: 1'b1, sub: 1'b0, hold: 0, res: 32'h0001_0001, co: 1'b0});
`ifdef MWADD_SUB_EN
        vecs.push_back('{a: 32'h0000_0005, b: 32'h0000_0007, cin: 1'b1, sub: 1'b1, hold: 0, res: 32'hFFFF_FFFE, co: 1'b0});
        vecs.push_back('{a: 32'h0000_0007, b: 32'h0000_0005, cin: 1'b0, sub: 1'b1, hold: 0, res: 32'h0000_0002, co: 1'b1});
        vecs.push_back('{a: 32'h0000_0009, b: 32'h0000_0009, cin: 1'b0, sub: 1'b0, hold: 0, res: 32'h0000_0012, co: 1'b0});
`endif

        // reset state
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        check("rst_ready", 64'(start_ready), 64'd1);
        check("rst_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_carry", 64'(carry_out), 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // reset during the second RUN cycle abandons the operation
        drive_start(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 1'b0);
        tick();
        start_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_ready", 64'(start_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(res_valid), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_carry", 64'(carry_out), 64'd0);
        repeat (WORDS) tick();
        check("abort_no_result", 64'(res_valid), 64'd0);
        run_vec('{a: 32'h0000_0001, b: 32'h0000_0001, cin: 1'b0, sub: 1'b0, hold: 0, res: 32'h0000_0002, co: 1'b0}, "after_abort");

        // back-to-back: start_valid held high across the result handshake
        exp_q.push_back(32'h0000_0003);
        exp_co_q.push_back(1'b0);
        drive_start(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
        tick();
        drive_start(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        wait_result("b2b_first");
        score("b2b_first");
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("b2b_no_accept_on_hs", 64'(busy), 64'd0);
        check("b2b_ready_after_hs", 64'(start_ready), 64'd1);
        exp_q.push_back(32'h0000_0030);
        exp_co_q.push_back(1'b0);
        tick();
        check("b2b_accept_next", 64'(busy), 64'd1);
        start_valid = 1'b0;
        wait_result("b2b_second");
        score("b2b_second");
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("b2b_final_idle", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the adder slice used per cycle; SHALL be >= 1.
REQ-002 Parameter WORDS, default 4: number of slices per operand; SHALL be >= 1; operand width N = WIDTH*WORDS.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 start_valid  input  1  requester presents an operation.
REQ-006 start_ready  output  1  block can accept an operation.
REQ-007 op_a  input  N  first operand.
REQ-008 op_b  input  N  second operand.
REQ-009 carry_in  input  1  initial carry into slice 0.
REQ-010 op_sub  input  1  subtract select; port exists only when MWADD_SUB_EN is defined.
REQ-011 res_valid  output  1  result available.
REQ-012 res_ready  input  1  consumer accepts result.
REQ-013 result  output  N  sum or difference.
REQ-014 carry_out  output  1  carry out of the most significant slice.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE; start_ready = 1 only in IDLE; res_valid = 1 only in DONE.
REQ-017 Acceptance SHALL occur on a rising edge where start_valid & start_ready; op_a, op_b, carry_in (and op_sub) are latched; slice index cleared to 0; carry register loaded with the initial carry; state -> RUN.
REQ-018 Operand inputs SHALL be ignored at all other times; later changes do not affect the operation in flight.
REQ-019 In RUN, each cycle SHALL compute exactly one WIDTH-bit slice k = index as {c, s} = a[k] + b'[k] + carry_reg, write s into result slice k, load c into carry_reg, and increment index.
REQ-020 Slices SHALL be processed LSB first; the edge processing slice WORDS-1 SHALL move the state to DONE and set carry_out = c.
REQ-021 Latency: res_valid SHALL rise exactly WORDS cycles after the acceptance edge; WORDS = 1 gives one cycle.
REQ-022 In DONE, result and carry_out SHALL be held stable until the edge where res_valid & res_ready; that edge moves the state to IDLE.
REQ-023 A new operation SHALL NOT be accepted on the same edge as the result handshake; the earliest next acceptance is the following edge (no overlap).
REQ-024 result and carry_out SHALL retain the last completed value in IDLE; result slices not yet written during RUN hold their previous values.
REQ-025 Arithmetic is modulo 2^N; carry out of slice k feeds slice k+1 only; there is no overflow flag besides carry_out.

Reset
REQ-026 When rst_n = 0 at a rising edge, the state SHALL become IDLE, index = 0, carry_reg = 0, result = 0, carry_out = 0, res_valid = 0, busy = 0; start_ready = 1 from the first edge with rst_n = 1.
REQ-027 Reset during RUN or DONE SHALL abandon the operation with no result handshake; reset takes priority over every other event on the same edge.

Configuration
REQ-028 Macro MWADD_SUB_EN defined: op_sub is present; op_sub = 1 computes op_a - op_b as op_a + ~op_b + 1 with carry_in ignored; carry_out = 1 means no borrow; op_sub = 0 is identical to add.
REQ-029 MWADD_SUB_EN undefined: no op_sub port; b' = op_b and the initial carry = carry_in, with no subtract hardware.

Verification (WIDTH=8, WORDS=4)
REQ-030 Accept op_a=0xFFFFFFFF, op_b=0x00000001, carry_in=0 -> res_valid exactly 4 cycles after acceptance, result=0x00000000, carry_out=1, busy high for those 4 cycles.
REQ-031 op_a=0x12345678, op_b=0x11111111, carry_in=1, res_ready held low 3 cycles in DONE -> result=0x2345678A, carry_out=0, stable throughout, start_ready=0 until the handshake.
REQ-032 Assert rst_n=0 for one edge during the 2nd RUN cycle -> next cycle IDLE, result=0, carry_out=0, res_valid=0; a subsequent add of 1+1 returns result=0x00000002.
REQ-033 Back-to-back: start_valid held high across the result handshake -> second acceptance occurs one edge after the handshake, not on it.
REQ-034 With MWADD_SUB_EN: op_sub=1, op_a=0x00000005, op_b=0x00000007, carry_in=1 -> result=0xFFFFFFFE, carry_out=0; op_a=7, op_b=5 -> result=0x00000002, carry_out=1.
